seq_alu: RTL and testbench

Parametrised, handshaked successor to the combinational MIPS ALU, decoding the same 6-bit R-type funct codes.
- Single-cycle ops (add/sub/logic/compare/shift) return a registered result one cycle after acceptance.
- MULT/MULTU/DIV/DIVU run on an iterative shift-add / restoring-divide datapath and return a HI/LO pair.
- Sits between register-read and writeback in the multi-cycle datapath; the controller stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/seq_alu_muldiv.sv | 119 +++++++++++
 rtl/seq_alu.sv | 142 ++++++++++++++
 tb/tb_seq_alu.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes, engine state enum and decode helper for seq_alu
package alu_pkg;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // MULT/MULTU/DIV/DIVU occupy 0110xx; bit1 selects divide, bit0 selects unsigned.
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// rtl/seq_alu_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   acc_nxt, prod_fix;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        a_neg       = op_signed && op_a[WIDTH-1];
        b_neg       = op_signed && op_b[WIDTH-1];
        a_mag       = a_neg ? -op_a : op_a;
        b_mag       = b_neg ? -op_b : op_b;
        div_by_zero = start && op_div && (op_b == '0);
        busy        = (state_q != ST_IDLE);

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd_q};

        if (state_q == ST_DIV) begin
            acc_nxt = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        end

        // Last iteration feeds the output register directly, saving a cycle.
        done     = div_by_zero || (busy && (cnt_q == CNT_LAST));
        prod_fix = neg_lo_q ? -acc_nxt : acc_nxt;

        if (div_by_zero) begin
            res_lo = '1;
            res_hi = op_a;
        end else if (state_q == ST_DIV) begin
            res_lo = neg_lo_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
            res_hi = neg_hi_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !div_by_zero) begin
                    state_d  = op_div ? ST_DIV : ST_MUL;
                    cnt_d    = '0;
                    opd_d    = op_div ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = op_div ? a_neg : (a_neg ^ b_neg);
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU: funct decode, single-cycle datapath, output register
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               alu_control,
    input  logic [WIDTH-1:0]         rs_content,
    input  logic [WIDTH-1:0]         rt_content,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result_lo,
    output logic [WIDTH-1:0]         result_hi,
    output logic                     overflow,
    output logic                     div_by_zero,
    output logic                     illegal_op
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic             md_busy, md_done, md_dz, md_start;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             accept, is_md;
    logic [WIDTH-1:0] sum, diff, sc_lo;
    logic             sc_ovf, sc_ill;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d;

    assign is_md    = is_muldiv(alu_control);
    assign in_ready = !md_busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_md;

    assign sum  = rs_content + rt_content;
    assign diff = rs_content - rt_content;

    always_comb begin
        sc_lo  = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (alu_control)
            FN_ADD: begin
                sc_lo  = sum;
                sc_ovf = (rs_content[WIDTH-1] == rt_content[WIDTH-1]) &&
                         (sum[WIDTH-1] != rs_content[WIDTH-1]);
            end
            FN_ADDU: sc_lo = sum;
            FN_SUB: begin
                sc_lo  = diff;
                sc_ovf = (rs_content[WIDTH-1] != rt_content[WIDTH-1]) &&
                         (diff[WIDTH-1] != rs_content[WIDTH-1]);
            end
            FN_SUBU: sc_lo = diff;
            FN_AND:  sc_lo = rs_content & rt_content;
            FN_OR:   sc_lo = rs_content | rt_content;
            FN_XOR:  sc_lo = rs_content ^ rt_content;
            FN_NOR:  sc_lo = ~(rs_content | rt_content);
            FN_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(rs_content) < $signed(rt_content))};
            FN_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (rs_content < rt_content)};
            FN_SLL:  sc_lo = rt_content << shamt;
            FN_SRL:  sc_lo = rt_content >> shamt;
            FN_SRA:  sc_lo = $signed(rt_content) >>> shamt;
            default: sc_ill = 1'b1;
        endcase
    end

    // The output slot is always empty when the engine finishes, since it only starts on in_ready.
    always_comb begin
        out_valid_d = out_valid_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        ill_d       = ill_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (md_done) begin
            out_valid_d = 1'b1;
            lo_d        = md_lo;
            hi_d        = md_hi;
            ovf_d       = 1'b0;
            dz_d        = md_dz;
            ill_d       = 1'b0;
        end else if (accept && !is_md) begin
            out_valid_d = 1'b1;
            lo_d        = sc_lo;
            hi_d        = '0;
            ovf_d       = sc_ovf;
            dz_d        = 1'b0;
            ill_d       = sc_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            ill_q       <= ill_d;
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (md_start),
        .op_div      (alu_control[1]),
        .op_signed   (!alu_control[0]),
        .op_a        (rs_content),
        .op_b        (rt_content),
        .busy        (md_busy),
        .done        (md_done),
        .div_by_zero (md_dz),
        .res_lo      (md_lo),
        .res_hi      (md_hi)
    );

    assign out_valid   = out_valid_q;
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with randomized ops and a reference model
module tb_seq_alu;

    localparam int W = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -MAXI - 64'sd1;
    localparam logic [5:0] CODES [17] = '{
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
        6'b000011, 6'b011000, 6'b011001, 6'b011010, 6'b011011};

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        logic        dz;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alu_control = '0;
    logic [31:0] rs_content = '0;
    logic [31:0] rt_content = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result_lo, result_hi;
    logic        overflow, div_by_zero, illegal_op;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   bp_until = 0;
    bit   rand_bp = 0;
    bit   prev_v = 0;
    bit   prev_hs = 0;
    int   st;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .rs_content  (rs_content),
        .rt_content  (rt_content),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        else         out_ready = (cyc >= bp_until);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint s;
        logic [63:0] p;
        int     sa, sb;
        e = '{default: 0};
        e.lat = 1;
        sa = a;
        sb = b;
        case (f)
            6'b100000: begin s = longint'(sa) + longint'(sb); e.lo = a + b; e.ovf = (s > MAXI) || (s < MINI); end
            6'b100001: e.lo = a + b;
            6'b100010: begin s = longint'(sa) - longint'(sb); e.lo = a - b; e.ovf = (s > MAXI) || (s < MINI); end
            6'b100011: e.lo = a - b;
            6'b100100: e.lo = a & b;
            6'b100101: e.lo = a | b;
            6'b100110: e.lo = a ^ b;
            6'b100111: e.lo = ~(a | b);
            6'b101010: e.lo = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: e.lo = (a < b) ? 32'd1 : 32'd0;
            6'b000000: e.lo = b << sh;
            6'b000010: e.lo = b >> sh;
            6'b000011: e.lo = sb >>> sh;
            6'b011000: begin p = longint'(sa) * longint'(sb); e.hi = p[63:32]; e.lo = p[31:0]; e.lat = W + 1; end
            6'b011001: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = W + 1; end
            6'b011010, 6'b011011: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lat = W + 1;
                    if (f[0]) begin
                        e.lo = a / b; e.hi = a % b;
                    end else if (a == 32'h80000000 && b == 32'hffffffff) begin
                        e.lo = a; e.hi = 0;
                    end else begin
                        e.lo = sa / sb; e.hi = sa % sb;
                    end
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int stalls);
        exp_t e;
        bit   done;
        stalls = 0;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        alu_control = f;
        rs_content = a;
        rt_content = b;
        shamt = sh;
        forever begin
            #1;
            if (in_ready === 1'b1) begin
                e = model(f, a, b, sh);
                e.acc = cyc;
                sb_q.push_back(e);
                done = 1;
            end else if (stalls >= 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
                break;
            end else begin
                stalls++;
            end
            @(posedge clk);
            if (done) break;
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        alu_control = 6'($urandom);
        rs_content = $urandom;
        rt_content = $urandom;
        shamt = 5'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffffffff;
            3: return 32'h80000000;
            4: return 32'h7fffffff;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_v = 0;
            prev_hs = 0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got lo %h with no request outstanding", result_lo);
                end else begin
                    mon_e = sb_q[0];
                    if (!prev_v || prev_hs) chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                    chk("result_lo", 64'(result_lo), 64'(mon_e.lo));
                    chk("result_hi", 64'(result_hi), 64'(mon_e.hi));
                    chk("flags_ovf_dz_ill", 64'({overflow, div_by_zero, illegal_op}),
                        64'({mon_e.ovf, mon_e.dz, mon_e.ill}));
                    if (out_ready) void'(sb_q.pop_front());
                    else chk("in_ready_under_backpressure", 64'(in_ready), 64'(0));
                end
            end
            prev_v = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    initial begin
        logic [5:0] f;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_lo_hi", 64'({result_lo, result_hi}), 64'(0));
        chk("reset_flags", 64'({overflow, div_by_zero, illegal_op}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        issue(6'b100010, 32'd52, 32'd4, 5'd0, st);
        issue(6'b100010, 32'd150, 32'd25, 5'd0, st);  chk("b2b_stalls", 64'(st), 64'(0));
        issue(6'b100010, 32'd15, 32'd15, 5'd0, st);   chk("b2b_stalls", 64'(st), 64'(0));
        issue(6'b100010, 32'd10, 32'd20, 5'd0, st);   chk("b2b_stalls", 64'(st), 64'(0));
        issue(6'b100010, 32'd0, 32'd7, 5'd0, st);     chk("b2b_stalls", 64'(st), 64'(0));
        issue(6'b100000, 32'h7fffffff, 32'd1, 5'd0, st);
        issue(6'b100001, 32'h7fffffff, 32'd1, 5'd0, st);
        issue(6'b101010, 32'hffffffff, 32'd1, 5'd0, st);
        issue(6'b101011, 32'hffffffff, 32'd1, 5'd0, st);
        issue(6'b000011, 32'd0, 32'h80000000, 5'd4, st);
        drain();

        issue(6'b011000, -32'sd3, 32'd7, 5'd0, st);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            #1;
            chk("in_ready_during_mult", 64'(in_ready), 64'(0));
        end
        drain();
        issue(6'b011001, 32'hffffffff, 32'd2, 5'd0, st);
        issue(6'b011010, -32'sd100, 32'd7, 5'd0, st);
        issue(6'b011011, 32'd100, 32'd0, 5'd0, st);
        issue(6'b011010, 32'h80000000, 32'hffffffff, 5'd0, st);
        drain();

        issue(6'b100000, 32'd5, 32'd6, 5'd0, st);
        bp_until = cyc + 5;
        issue(6'b100101, 32'h00f0, 32'h0f00, 5'd0, st);
        chk("backpressure_stalls", 64'(st), 64'(5));
        drain();

        issue(6'b100000, 32'h1000, 32'h0234, 5'd0, st);
        drain();
        issue(6'b011000, 32'd5, 32'd6, 5'd0, st);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_out_valid", 64'(out_valid), 64'(0));
        chk("midop_reset_lo_hi", 64'({result_lo, result_hi}), 64'(0));
        chk("midop_reset_flags", 64'({overflow, div_by_zero, illegal_op}), 64'(0));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'(1));
        issue(6'b111111, 32'h12345678, 32'h9abcdef0, 5'd3, st);
        drain();

        rand_bp = 1;
        for (int i = 0; i < 250; i++) begin
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : CODES[$urandom_range(0, 16)];
            issue(f, rnd_opnd(), rnd_opnd(), 5'($urandom), st);
        end
        drain();
        rand_bp = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
